// File: rtl/sound_latch_mailbox.sv
// M68K -> Z80 sound command mailbox: one 8-bit latch with pending/overrun status,
// a level-held Z80 interrupt and an M68K-readable status word.
module sound_latch_mailbox #(
  parameter bit         CLEAR_ON_READ = 1'b0,
  parameter logic [7:0] INT_VECTOR    = 8'hff
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m68k_latch_cs,
  input  logic        m68k_sound_cs,
  input  logic        m68k_lds_n,
  input  logic [7:0]  m68k_din,
  output logic [15:0] m68k_dout,
  input  logic        z80_latch_cs,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic        IORQ_n,
  input  logic        M1_n,
  output logic [7:0]  z80_dout,
  output logic [7:0]  z80_int_vec,
  output logic        z80_int_n,
  output logic        latch_pending,
  output logic        overrun
);

  logic [7:0] latch;
  logic       pending;
  logic       overrun_q;

  logic m68k_wr_lvl, m68k_rd_lvl, z80_rd_lvl, z80_wr_lvl;
  logic m68k_wr_q, m68k_rd_q, z80_rd_q, z80_wr_q;
  logic m68k_wr_evt, m68k_rd_evt, z80_rd_evt, z80_wr_evt;
  logic z80_clear_evt;
  logic int_ack;

  assign m68k_wr_lvl = m68k_latch_cs & ~m68k_lds_n;
  assign m68k_rd_lvl = m68k_sound_cs;
  assign z80_rd_lvl  = z80_latch_cs & ~RD_n;
  assign z80_wr_lvl  = z80_latch_cs & ~WR_n;

  assign m68k_wr_evt = m68k_wr_lvl & ~m68k_wr_q;
  assign m68k_rd_evt = m68k_rd_lvl & ~m68k_rd_q;
  assign z80_rd_evt  = z80_rd_lvl & ~z80_rd_q;
  assign z80_wr_evt  = z80_wr_lvl & ~z80_wr_q;

  assign z80_clear_evt = z80_wr_evt | (CLEAR_ON_READ & z80_rd_evt);
  assign int_ack       = ~M1_n & ~IORQ_n;

  // Edge registers load the live strobe level during reset so that a strobe
  // still held when reset releases is not mistaken for a fresh access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m68k_wr_q <= m68k_wr_lvl;
      m68k_rd_q <= m68k_rd_lvl;
      z80_rd_q  <= z80_rd_lvl;
      z80_wr_q  <= z80_wr_lvl;
    end else begin
      m68k_wr_q <= m68k_wr_lvl;
      m68k_rd_q <= m68k_rd_lvl;
      z80_rd_q  <= z80_rd_lvl;
      z80_wr_q  <= z80_wr_lvl;
    end
  end

  // A new M68K command beats a same-cycle Z80 clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch   <= 8'h00;
      pending <= 1'b0;
    end else if (m68k_wr_evt) begin
      latch   <= m68k_din;
      pending <= 1'b1;
    end else if (z80_clear_evt) begin
      pending <= 1'b0;
    end
  end

  // Setting overrun has priority over the M68K status-read clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (m68k_wr_evt && pending && !z80_clear_evt) begin
      overrun_q <= 1'b1;
    end else if (m68k_rd_evt) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z80_dout    <= 8'h00;
      z80_int_n   <= 1'b1;
      m68k_dout   <= 16'h0000;
      z80_int_vec <= INT_VECTOR;
    end else begin
      z80_dout  <= latch;
      z80_int_n <= ~pending;
      m68k_dout <= {14'h0000, overrun_q, pending};
      if (int_ack)
        z80_int_vec <= INT_VECTOR;
    end
  end

  assign latch_pending = pending;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_sound_latch_mailbox.sv
// Directed bench for sound_latch_mailbox: handshake, overrun, write/clear race
// and reset while a strobe is held.
module tb_sound_latch_mailbox;

  logic        clk;
  logic        reset_n;
  logic        m68k_latch_cs;
  logic        m68k_sound_cs;
  logic        m68k_lds_n;
  logic [7:0]  m68k_din;
  logic [15:0] m68k_dout;
  logic        z80_latch_cs;
  logic        RD_n;
  logic        WR_n;
  logic        IORQ_n;
  logic        M1_n;
  logic [7:0]  z80_dout;
  logic [7:0]  z80_int_vec;
  logic        z80_int_n;
  logic        latch_pending;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  sound_latch_mailbox #(.CLEAR_ON_READ(1'b0), .INT_VECTOR(8'hff)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m68k_latch_cs (m68k_latch_cs),
    .m68k_sound_cs (m68k_sound_cs),
    .m68k_lds_n    (m68k_lds_n),
    .m68k_din      (m68k_din),
    .m68k_dout     (m68k_dout),
    .z80_latch_cs  (z80_latch_cs),
    .RD_n          (RD_n),
    .WR_n          (WR_n),
    .IORQ_n        (IORQ_n),
    .M1_n          (M1_n),
    .z80_dout      (z80_dout),
    .z80_int_vec   (z80_int_vec),
    .z80_int_n     (z80_int_n),
    .latch_pending (latch_pending),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic m68k_write(input logic [7:0] d);
    m68k_din = d; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    step(2);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    step(1);
  endtask

  task automatic z80_write;
    z80_latch_cs = 1'b1; WR_n = 1'b0;
    step(2);
    z80_latch_cs = 1'b0; WR_n = 1'b1;
    step(1);
  endtask

  initial begin
    reset_n = 1'b0;
    m68k_latch_cs = 1'b0; m68k_sound_cs = 1'b0; m68k_lds_n = 1'b1; m68k_din = 8'h00;
    z80_latch_cs = 1'b0; RD_n = 1'b1; WR_n = 1'b1; IORQ_n = 1'b1; M1_n = 1'b1;
    step(3);
    reset_n = 1'b1;
    step(1);

    check("rst_pending",  {15'd0, latch_pending}, 16'h0000);
    check("rst_overrun",  {15'd0, overrun},       16'h0000);
    check("rst_int_n",    {15'd0, z80_int_n},     16'h0001);
    check("rst_z80_dout", {8'd0, z80_dout},       16'h0000);
    check("rst_m68k_dout", m68k_dout,             16'h0000);
    check("rst_int_vec",  {8'd0, z80_int_vec},    16'h00ff);

    // 0x5A held 6 clocks; data changes mid-hold must not re-trigger
    m68k_din = 8'h5a; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    step(1);
    check("wr_pending_1clk", {15'd0, latch_pending}, 16'h0001);
    check("wr_int_n_1clk",   {15'd0, z80_int_n},     16'h0001);
    step(1);
    check("wr_int_n_2clk",   {15'd0, z80_int_n},     16'h0000);
    check("wr_z80_dout",     {8'd0, z80_dout},       16'h005a);
    m68k_din = 8'hee;
    step(4);
    check("wr_single_event", {8'd0, z80_dout},       16'h005a);
    check("wr_no_overrun",   {15'd0, overrun},       16'h0000);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    step(1);

    z80_latch_cs = 1'b1; RD_n = 1'b0;
    step(2);
    check("rd_data",         {8'd0, z80_dout},       16'h005a);
    check("rd_keeps_pending", {15'd0, latch_pending}, 16'h0001);
    z80_latch_cs = 1'b0; RD_n = 1'b1;
    step(1);

    z80_latch_cs = 1'b1; WR_n = 1'b0;
    step(1);
    check("ack_pending",     {15'd0, latch_pending}, 16'h0000);
    step(1);
    check("ack_int_n",       {15'd0, z80_int_n},     16'h0001);
    z80_latch_cs = 1'b0; WR_n = 1'b1;
    step(1);

    m68k_write(8'h11);
    m68k_write(8'h22);
    step(1);
    check("ovr_latch",       {8'd0, z80_dout},       16'h0022);
    check("ovr_flag",        {15'd0, overrun},       16'h0001);
    check("ovr_status",      m68k_dout,              16'h0003);

    m68k_sound_cs = 1'b1;
    step(1);
    check("stat_read_value", m68k_dout,              16'h0003);
    step(1);
    check("stat_after_read", m68k_dout,              16'h0001);
    check("stat_ovr_clear",  {15'd0, overrun},       16'h0000);
    m68k_sound_cs = 1'b0;
    step(1);

    z80_write();
    check("pre_race_clear",  {15'd0, latch_pending}, 16'h0000);

    // write and clear edges land on the same clock
    m68k_din = 8'h33; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    z80_latch_cs = 1'b1; WR_n = 1'b0;
    step(1);
    check("race_pending",    {15'd0, latch_pending}, 16'h0001);
    step(1);
    check("race_latch",      {8'd0, z80_dout},       16'h0033);
    check("race_int_n",      {15'd0, z80_int_n},     16'h0000);
    check("race_overrun",    {15'd0, overrun},       16'h0000);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    z80_latch_cs = 1'b0; WR_n = 1'b1;
    step(1);

    M1_n = 1'b0; IORQ_n = 1'b0;
    step(1);
    check("int_ack_vec",     {8'd0, z80_int_vec},    16'h00ff);
    check("int_ack_level",   {15'd0, z80_int_n},     16'h0000);
    M1_n = 1'b1; IORQ_n = 1'b1;
    step(1);

    // reset while an M68K strobe is held with 0x77
    m68k_din = 8'h77; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0; reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    check("rsth_pending",    {15'd0, latch_pending}, 16'h0000);
    check("rsth_latch",      {8'd0, z80_dout},       16'h0000);
    check("rsth_int_n",      {15'd0, z80_int_n},     16'h0001);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    step(1);
    m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    step(1);
    check("rsth_rearm_pend", {15'd0, latch_pending}, 16'h0001);
    step(1);
    check("rsth_rearm_data", {8'd0, z80_dout},       16'h0077);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
